// File: rtl/mem_init_ram.sv
// mem_init_ram: byte-enabled RAM with combinational reads and a hardware fill sequencer.
// Optional sticky port A error flag is built when MEM_INIT_RAM_BOUNDS_CHECK_EN is defined.
module mem_init_ram #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int NUM_ENTRIES = 256,
    parameter     FILL_VALUE  = 16'h0020
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                init_req_i,
    output logic                init_busy_o,
    output logic                init_done_o,
    input  logic                a_wr_i,
    input  logic [DATA_W/8-1:0] a_be_i,
    input  logic [ADDR_W-1:0]   a_addr_i,
    input  logic [DATA_W-1:0]   a_wdata_i,
    output logic [DATA_W-1:0]   a_rdata_o,
    input  logic [ADDR_W-1:0]   b_addr_i,
    output logic [DATA_W-1:0]   b_rdata_o,
    output logic                a_err_o
);

    localparam int                BE_W      = DATA_W / 8;
    localparam int                CNT_W     = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NUM_ENTRIES - 1);
    localparam logic [ADDR_W:0]   LIMIT     = (ADDR_W + 1)'(NUM_ENTRIES);
    localparam logic [DATA_W-1:0] FILL_WORD = DATA_W'(FILL_VALUE);

    typedef enum logic {
        FILL,
        IDLE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fill_we;
    logic              a_in_range, b_in_range, a_we;
    logic [DATA_W-1:0] mem [NUM_ENTRIES];

    // One extra compare bit so NUM_ENTRIES == 2**ADDR_W never aliases.
    assign a_in_range = {1'b0, a_addr_i} < LIMIT;
    assign b_in_range = {1'b0, b_addr_i} < LIMIT;
    assign a_we       = a_wr_i && (state_q == IDLE) && a_in_range;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= FILL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_we = 1'b0;
        case (state_q)
            FILL: begin
                fill_we = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (init_req_i) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // NOTE: the array has no reset; the fill sequencer is what gives it defined contents.
    always_ff @(posedge clk_i) begin
        if (fill_we) begin
            mem[cnt_q] <= FILL_WORD;
        end else if (a_we) begin
            for (int k = 0; k < BE_W; k++) begin
                if (a_be_i[k]) mem[a_addr_i[CNT_W-1:0]][8*k +: 8] <= a_wdata_i[8*k +: 8];
            end
        end
    end

    assign a_rdata_o   = a_in_range ? mem[a_addr_i[CNT_W-1:0]] : '0;
    assign b_rdata_o   = b_in_range ? mem[b_addr_i[CNT_W-1:0]] : '0;
    assign init_busy_o = (state_q == FILL);
    assign init_done_o = (state_q == IDLE);

`ifdef MEM_INIT_RAM_BOUNDS_CHECK_EN
    logic err_q, err_set, err_clr;

    assign err_set = ((a_wr_i || (a_be_i != '0)) && !a_in_range)
                   || (a_wr_i && (state_q == FILL));
    assign err_clr = (state_q == IDLE) && init_req_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= err_set || (err_q && !err_clr);
    end

    assign a_err_o = err_q;
`else
    assign a_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_init_ram.sv
// Directed self-checking bench for mem_init_ram with default parameters.
// Expected a_err_o follows whether MEM_INIT_RAM_BOUNDS_CHECK_EN is defined.
module tb_mem_init_ram;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
`ifdef MEM_INIT_RAM_BOUNDS_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              init_req = 1'b0;
    logic              init_busy, init_done;
    logic              a_wr = 1'b0;
    logic [1:0]        a_be = '0;
    logic [ADDR_W-1:0] a_addr = '0;
    logic [DATA_W-1:0] a_wdata = '0;
    logic [DATA_W-1:0] a_rdata;
    logic [ADDR_W-1:0] b_addr = '0;
    logic [DATA_W-1:0] b_rdata;
    logic              a_err;

    int n_checks = 0;
    int n_errors = 0;
    int k;
    int n_fill;
    logic done_seen;

    mem_init_ram dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .init_req_i  (init_req),
        .init_busy_o (init_busy),
        .init_done_o (init_done),
        .a_wr_i      (a_wr),
        .a_be_i      (a_be),
        .a_addr_i    (a_addr),
        .a_wdata_i   (a_wdata),
        .a_rdata_o   (a_rdata),
        .b_addr_i    (b_addr),
        .b_rdata_o   (b_rdata),
        .a_err_o     (a_err)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_a(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                           input logic [1:0] be);
        a_wr    = 1'b1;
        a_addr  = addr;
        a_wdata = data;
        a_be    = be;
        tick();
        a_wr = 1'b0;
        a_be = '0;
    endtask

    // Counts cycles until init_busy drops, bounded; notes any init_done seen meanwhile.
    task automatic wait_fill(output int n, output logic seen);
        n    = 0;
        seen = 1'b0;
        while (init_busy && n < 400) begin
            if (init_done) seen = 1'b1;
            tick();
            n++;
        end
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_busy", init_busy, 1);
        check("rst_done", init_done, 0);
        check("rst_err", a_err, 0);

        // Reset-fill
        rst_i = 1'b0;
        wait_fill(n_fill, done_seen);
        check("fill_len", n_fill, 256);
        check("fill_done_early", done_seen, 0);
        check("fill_done", init_done, 1);
        a_addr = 16'd0;   #1 check("fill_rd0", a_rdata, 16'h0020);
        a_addr = 16'd128; #1 check("fill_rd128", a_rdata, 16'h0020);
        a_addr = 16'd255; #1 check("fill_rd255", a_rdata, 16'h0020);
        b_addr = 16'd255; #1 check("fill_b255", b_rdata, 16'h0020);

        // Byte-enable writes
        write_a(16'd5, 16'hABCD, 2'b01);
        b_addr = 16'd5; #1 check("be_low", b_rdata, 16'h00CD);
        write_a(16'd5, 16'h1234, 2'b10);
        #1 check("be_high", b_rdata, 16'h12CD);
        write_a(16'd5, 16'hFFFF, 2'b00);
        #1 check("be_none", b_rdata, 16'h12CD);

        // Read during write: old value this cycle, new value next cycle
        a_wr = 1'b1; a_addr = 16'd7; a_wdata = 16'h5555; a_be = 2'b11; b_addr = 16'd7;
        #1;
        check("rdw_b_old", b_rdata, 16'h0020);
        check("rdw_a_old", a_rdata, 16'h0020);
        tick();
        a_wr = 1'b0; a_be = '0;
        check("rdw_b_new", b_rdata, 16'h5555);

        // Out-of-range write
        write_a(16'h0100, 16'h7777, 2'b11);
        check("oor_err", a_err, EXP_ERR);
        a_addr = 16'h0000; #1 check("oor_alias0", a_rdata, 16'h0020);
        a_addr = 16'h0100; #1 check("oor_rd100", a_rdata, 16'h0000);
        a_addr = 16'hFFFF; #1 check("oor_rdffff", a_rdata, 16'h0000);
        tick();
        check("oor_err_sticky", a_err, EXP_ERR);

        // Writes during fill are dropped; init_req during fill is ignored
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        k = 0;
        check("req_busy", init_busy, 1);
        check("req_done", init_done, 0);
        check("req_err_clr", a_err, 0);
        tick(); k++;
        tick(); k++;
        a_wr = 1'b1; a_addr = 16'd250; a_wdata = 16'hFFFF; a_be = 2'b11;
        tick(); k++;
        a_addr = 16'd1; init_req = 1'b1;
        tick(); k++;
        a_wr = 1'b0; a_be = '0; init_req = 1'b0;
        b_addr = 16'd7; #1 check("partial_b7", b_rdata, 16'h5555);
        check("busy_wr_dropped", a_rdata, 16'h0020);
        while (init_busy && k < 400) begin
            tick();
            k++;
        end
        check("refill_len", k, 256);
        a_addr = 16'd250; #1 check("busy_wr_250", a_rdata, 16'h0020);
        check("refill_b7", b_rdata, 16'h0020);
        check("busy_wr_err", a_err, EXP_ERR);

        // Reset mid-fill restarts a full fill
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        repeat (100) tick();
        rst_i = 1'b1;
        #1;
        check("midrst_busy", init_busy, 1);
        check("midrst_done", init_done, 0);
        check("midrst_err", a_err, 0);
        tick();
        tick();
        rst_i = 1'b0;
        wait_fill(n_fill, done_seen);
        check("midrst_len", n_fill, 256);
        check("midrst_done_early", done_seen, 0);
        check("midrst_final_done", init_done, 1);

        // Asynchronous reset from IDLE, no clock edge
        rst_i = 1'b1;
        #1;
        check("async_busy", init_busy, 1);
        check("async_done", init_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_init_ram.md
Name: mem_init_ram

Overview:
- Parametrised single-cycle-write, combinational-read memory for the lab4 CPU datapath.
- Serves as the successor to the 16-bit, 256-entry register-like RAM.
- Port A is read/write with byte enables (data memory / load-store unit). Port B is read-only (instruction fetch or debug).
- Contents are initialised by a hardware fill sequencer, one entry per cycle after reset or on request, instead of a file read at reset. Software loads images through port A after init_done_o.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8.
- ADDR_W, 16, address port width in bits.
- NUM_ENTRIES, 256, number of words; must satisfy 1 <= NUM_ENTRIES <= 2**ADDR_W.
- FILL_VALUE, 16'h0020, word written to every entry by the fill sequencer; zero-extended or truncated to DATA_W.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- init_req_i  input  1  pulse; restarts the fill sequence when idle.
- init_busy_o  output  1  high while the fill sequencer owns the array.
- init_done_o  output  1  high once a fill has completed and no fill is running.
- a_wr_i  input  1  port A write strobe.
- a_be_i  input  DATA_W/8  port A byte enables; bit k covers bits [8k+7:8k].
- a_addr_i  input  ADDR_W  port A word address.
- a_wdata_i  input  DATA_W  port A write data.
- a_rdata_o  output  DATA_W  port A read data (combinational).
- b_addr_i  input  ADDR_W  port B word address.
- b_rdata_o  output  DATA_W  port B read data (combinational).
- a_err_o  output  1  port A out-of-range access flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, rst_i=1)
  - FSM to FILL, fill counter to 0, init_busy_o=1, init_done_o=0, a_err_o=0.
  - The array itself is not reset.
  - Reset asserted mid-fill restarts the fill from entry 0 once rst_i falls.
- FSM states: FILL, IDLE.
  - FILL: each cycle writes FILL_VALUE to mem[cnt] and increments cnt. On the edge where cnt==NUM_ENTRIES-1, go to IDLE and clear cnt.
  - Fill duration is exactly NUM_ENTRIES cycles after reset release.
  - IDLE: init_busy_o=0, init_done_o=1. If init_req_i=1, go to FILL with cnt=0 and init_done_o=0 on the next cycle.
  - init_req_i while in FILL is ignored; the fill is not restarted.
- Port A write
  - When a_wr_i=1, state IDLE, and a_addr_i < NUM_ENTRIES: on the rising edge, bytes with a_be_i[k]=1 take a_wdata_i; other bytes are unchanged.
  - a_wr_i=1 with a_be_i all zero leaves memory unchanged.
  - Latency is one cycle: the written value is visible on the read ports in the following cycle.
- Writes are silently dropped during FILL. No backpressure: the caller must gate on init_busy_o.
- Reads
  - a_rdata_o = mem[a_addr_i] and b_rdata_o = mem[b_addr_i], combinational, in every state, including during FILL (partially filled contents are visible).
  - Out-of-range addresses (>= NUM_ENTRIES) read as 0.
- Simultaneous events
  - Port A write with a port A or port B read of the same address in the same cycle: reads return the old value that cycle and the new value the next cycle.
  - Port B never writes, so there are no write-write conflicts.
- Width rules
  - Counter width is clog2(NUM_ENTRIES), minimum 1.
  - Address compares use the full ADDR_W; no wrap-around or aliasing of out-of-range addresses.
- Out-of-range port A writes are ignored; the array is never modified outside 0..NUM_ENTRIES-1.

Optional Feature:
- Macro: MEM_INIT_RAM_BOUNDS_CHECK_EN.
- Defined: a_err_o is a registered flag. It is set on the rising edge after any port A access (read or write, i.e. a_wr_i=1 or any address presented while a_wr_i=0 counts only when a_wr_i=1 or a_be_i!=0) whose a_addr_i >= NUM_ENTRIES, or any a_wr_i=1 during FILL. It is sticky until reset or init_req_i is accepted in IDLE.
- Not defined: a_err_o is tied to 0 and no checking logic is synthesised. All other behaviour is identical.

Test Plan:
- Reset-fill: pulse rst_i, then release with defaults. Required: init_busy_o=1 for exactly 256 cycles, then init_done_o=1; a_rdata_o at addresses 0, 128 and 255 all read 16'h0020.
- Byte-enable write: in IDLE, write a_addr_i=5, a_wdata_i=16'hABCD, a_be_i=2'b01. Required: next cycle b_addr_i=5 reads 16'h00CD. Then write 16'h1234 with a_be_i=2'b10: next cycle reads 16'h12CD.
- Read-during-write: write 16'h5555 to address 7 while b_addr_i=7. Required: b_rdata_o=16'h0020 in that cycle and 16'h5555 in the next cycle.
- Write during fill: assert init_req_i, then 3 cycles later write 16'hFFFF to address 250. Required: after fill completes, address 250 reads 16'h0020; with MEM_INIT_RAM_BOUNDS_CHECK_EN defined, a_err_o=1.
- Out of range: with NUM_ENTRIES=256, write 16'h7777 to address 16'h0100. Required: address 0 is unchanged; a_rdata_o at 16'h0100 reads 0; a_err_o=1 only with the macro defined.
- Reset mid-fill: assert rst_i at fill cycle 100. Required: after release, init_busy_o=1 for a full 256 cycles again and init_done_o=0 throughout.
